// File: rtl/mmio_uart_tx_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - byte offsets of the registers inside the 16-byte window
//   - STATUS / CTRL bit positions
//   - transmitter FSM state type
//   - helper that saturates the FIFO count into the 4-bit STATUS field
package uart_pkg;

  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] CTRL_OFS   = 4'h8;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [3:0] sat_cnt4(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-port view of the UART register window.
//   we    : CPU write enable
//   addr  : CPU byte address
//   wdata : CPU store data
//   rdata : register read data (combinational from addr)
//   hit   : addr falls inside the UART window
// master = CPU side, slave = UART side.
interface mmio_uart_tx_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output we, output addr, output wdata, input rdata, input hit);
  modport slave  (input we, input addr, input wdata, output rdata, output hit);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head data.
//   clk, reset : clock, synchronous active-high reset (flushes pointers/count)
//   i_push     : write i_wdata; honoured when not full or when popping too
//   i_pop      : drop the head entry; ignored when empty
//   o_rdata    : head entry
//   o_full, o_empty, o_count : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
//   clk, reset : clock, synchronous active-high reset
//   bus        : CPU data port (slave side) - we/addr/wdata in, rdata/hit out
//   txd        : registered serial output, idles high
//   irq        : registered; IE set, FIFO empty and transmitter idle
// Registers (offset addr[3:2]): TXDATA push, STATUS, CTRL, reserved.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          txd,
  output logic          irq
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  tx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift;
  logic             r_txd, r_irq, r_en, r_ie, r_ovf;

  logic             w_hit, w_wr, w_push_req, w_ovf_clr, w_ctrl_wr;
  logic [3:0]       w_ofs;
  logic             w_pop, w_bit_end, w_busy;
  logic             w_full, w_empty;
  logic [7:0]       w_fifo_rdata;
  logic [FC_W-1:0]  w_count;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Address decode; only addr[3:2] selects a register inside the window.
  assign w_hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_ofs      = {bus.addr[3:2], 2'b00};
  assign w_wr       = bus.we & w_hit;
  assign w_push_req = w_wr && (w_ofs == TXDATA_OFS);
  assign w_ovf_clr  = w_wr && (w_ofs == STATUS_OFS) && bus.wdata[ST_OVF];
  assign w_ctrl_wr  = w_wr && (w_ofs == CTRL_OFS);
  assign w_unused   = ^{bus.addr[1:0], bus.wdata[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_wdata (bus.wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en  <= 1'b1;
      r_ie  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_en <= bus.wdata[CTRL_EN];
        r_ie <= bus.wdata[CTRL_IE];
      end
      // Drop is only a real loss when nothing leaves the FIFO this cycle.
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_ovf_clr)                 r_ovf <= 1'b0;
    end
  end

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_busy    = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_pop       = 1'b0;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (r_en && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit so frames stay contiguous.
        if (w_bit_end) begin
          if (r_en && !w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      case (r_state)
        S_START: r_txd <= 1'b0;
        S_DATA:  r_txd <= r_shift[r_bit];
        default: r_txd <= 1'b1;
      endcase
      r_irq <= r_ie & w_empty & (r_state == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_shift <= w_fifo_rdata;
  end

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      STATUS_OFS: begin
        w_rdata[ST_BUSY]         = w_busy;
        w_rdata[ST_FULL]         = w_full;
        w_rdata[ST_EMPTY]        = w_empty;
        w_rdata[ST_OVF]          = r_ovf;
        w_rdata[ST_CNT_LSB +: 4] = sat_cnt4(32'(w_count));
      end
      CTRL_OFS: begin
        w_rdata[CTRL_EN] = r_en;
        w_rdata[CTRL_IE] = r_ie;
      end
      default: w_rdata = '0;
    endcase
  end

  assign bus.rdata = w_rdata;
  assign bus.hit   = w_hit;
  assign txd       = r_txd;
  assign irq       = r_irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized scoreboard bench for mmio_uart_tx.
// Bytes expected on the line are queued when written; an independent serial
// monitor decodes txd frames and pops/compares against that queue.
module tb_mmio_uart_tx;
  localparam int          D     = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_CT  = BASE + 32'h8;
  localparam logic [31:0] A_RS  = BASE + 32'hC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd, irq;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Serial monitor: find start edge, sample mid-bit, compare with scoreboard.
  logic       mon_prev = 1'b1;
  bit         mon_in = 1'b0;
  int         mon_ph = 0;
  int         mon_k = 0;
  logic [9:0] mon_bits = '0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (reset) begin
      mon_in = 1'b0;
    end else if (!mon_in) begin
      if (mon_prev && !txd) begin
        mon_in = 1'b1;
        mon_ph = 0;
        mon_k  = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_ph++;
    end
    if (mon_in && !reset && (mon_ph % D == D / 2)) begin
      mon_bits = {txd, mon_bits[9:1]};
      mon_k++;
      if (mon_k == 10) begin
        mon_in = 1'b0;
        frames++;
        chk("start_bit", 32'(mon_bits[0]), 32'd0);
        chk("stop_bit", 32'(mon_bits[9]), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got byte 0x%02h expected no frame", mon_bits[8:1]);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("frame_byte", 32'(mon_bits[8:1]), 32'(mon_exp));
        end
      end
    end
    mon_prev = txd;
  end

  // Reference helpers derived from the register map.
  function automatic logic [31:0] status_word(input bit busy, input bit full, input bit empty,
                                               input bit ovf, input int cnt);
    logic [31:0] s;
    s = '0;
    s[0] = busy;
    s[1] = full;
    s[2] = empty;
    s[3] = ovf;
    s[11:8] = (cnt > 15) ? 4'hF : 4'(cnt);
    return s;
  endfunction

  // Back-to-back writes into an idle block: one byte leaves for the shifter
  // immediately, the FIFO holds DEPTH more.
  function automatic int exp_accepted(input int n);
    return (n <= DEPTH + 1) ? n : DEPTH + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic wait_idle(input int budget, input bit need_empty, input string name);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      rd(A_ST, s);
      if (!s[0] && (!need_empty || s[2])) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  logic [31:0] rv;
  logic [9:0]  frame;
  logic [7:0]  b;
  int          bad, bad2, f0, nacc, sp;
  bit          done;
  logic        expbit;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and idle behaviour
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (txd !== 1'b1 || irq !== 1'b0) bad++;
    end
    chk("idle_50_bad_cycles", 32'(bad), 32'd0);
    rd(A_ST, rv); chk("rst_status", rv, status_word(0, 0, 1, 0, 0));
    rd(A_CT, rv); chk("rst_ctrl", rv, 32'h1);
    rd(A_TX, rv); chk("txdata_read", rv, 32'h0);
    tick();
    rd(A_RS, rv); chk("reserved_read", rv, 32'h0);
    chk("hit_in_window", 32'(bus.hit), 32'd1);
    bus.addr = 32'h0000_FF10; #1;
    chk("hit_above_window", 32'(bus.hit), 32'd0);
    tick();

    // Single 0x5A frame, cycle-exact waveform
    exp_q.push_back(8'h5A);
    frame = {1'b1, 8'h5A, 1'b0};
    wr(A_TX, 32'h5A);
    bad = 0;
    for (int t = 1; t <= 42; t++) begin
      tick();
      if (t < 2 || t > 41) expbit = 1'b1;
      else                 expbit = 1'(frame >> ((t - 2) / D));
      if (txd !== expbit) bad++;
      if (t == 40) begin rd(A_ST, rv); chk("busy_at_40", 32'(rv[0]), 32'd1); end
      if (t == 41) begin rd(A_ST, rv); chk("busy_at_41", 32'(rv[0]), 32'd0); end
    end
    chk("txd_wave_bad_cycles", 32'(bad), 32'd0);
    wait_idle(20, 1'b1, "idle_after_5a");

    // Nine back-to-back writes fill shifter + FIFO; the tenth overflows
    nacc = exp_accepted(9);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < nacc) exp_q.push_back(b);
      wr(A_TX, 32'(b));
    end
    rd(A_ST, rv); chk("status_after_9", rv, status_word(1, 1, 0, 0, DEPTH));
    wr(A_TX, 32'($urandom_range(0, 255)));
    rd(A_ST, rv); chk("status_overflow", rv, status_word(1, 1, 0, 1, DEPTH));
    wr(A_ST, 32'h7);
    rd(A_ST, rv); chk("ovf_kept_bit3_zero", 32'(rv[3]), 32'd1);
    wr(A_ST, 32'h8);
    rd(A_ST, rv); chk("status_ovf_cleared", rv, status_word(1, 1, 0, 0, DEPTH));
    wait_idle(9 * 10 * D + 50, 1'b1, "drain_9");

    // Three queued bytes: frames contiguous, 30*CLK_DIV overall
    start_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      wr(A_TX, 32'(b));
    end
    wait_idle(3 * 10 * D + 50, 1'b1, "drain_3");
    sp = start_q.size();
    chk("three_frames_seen", 32'(sp), 32'd3);
    if (sp == 3) begin
      chk("gap_frame1_2", 32'(start_q[1] - start_q[0]), 32'(10 * D));
      chk("span_3_frames", 32'(start_q[2] - start_q[0] + 10 * D), 32'(30 * D));
    end

    // Reset during DATA bit 4 with a second byte waiting
    wr(A_TX, 32'($urandom_range(0, 255)));
    wr(A_TX, 32'($urandom_range(0, 255)));
    repeat (21) tick();
    reset = 1'b1;
    tick();
    chk("txd_after_reset", 32'(txd), 32'd1);
    reset = 1'b0;
    rd(A_ST, rv); chk("status_after_reset", rv, status_word(0, 0, 1, 0, 0));
    f0 = frames;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1) bad++;
    end
    chk("no_start_after_reset", 32'(bad), 32'd0);
    chk("frames_after_reset", 32'(frames), 32'(f0));

    // EN gating: held while disabled, sent on enable, finish-current on clear
    wr(A_CT, 32'h0);
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    wr(A_TX, 32'(b));
    f0 = frames;
    repeat (60) tick();
    rd(A_ST, rv); chk("status_en0_held", rv, status_word(0, 0, 0, 0, 1));
    chk("frames_en0", 32'(frames), 32'(f0));
    wr(A_CT, 32'h1);
    wait_idle(10 * D + 20, 1'b1, "drain_en1");
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      wr(A_TX, 32'(b));
    end
    repeat (10) tick();
    wr(A_CT, 32'h0);
    wait_idle(10 * D + 20, 1'b0, "frame_done_en0");
    rd(A_ST, rv); chk("status_en_cleared_mid", rv, status_word(0, 0, 0, 0, 1));
    wr(A_CT, 32'h1);
    wait_idle(10 * D + 20, 1'b1, "drain_after_reenable");

    // Interrupt behaviour
    wr(A_CT, 32'h3);
    tick();
    chk("irq_idle_ie", 32'(irq), 32'd1);
    rd(A_CT, rv); chk("ctrl_readback", rv, 32'h3);
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    wr(A_TX, 32'(b));
    tick();
    tick();
    bad2 = 0;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rd(A_ST, rv);
      if (!rv[0]) begin done = 1'b1; break; end
      if (irq !== 1'b0) bad2++;
      tick();
    end
    chk("irq_low_while_busy", 32'(bad2), 32'd0);
    chk("irq_frame_done", 32'(done), 32'd1);
    tick();
    chk("irq_after_stop", 32'(irq), 32'd1);
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    wr(A_TX, 32'(b));
    tick();
    chk("irq_cleared_on_write", 32'(irq), 32'd0);
    wait_idle(10 * D + 20, 1'b1, "drain_irq");
    wr(A_CT, 32'h1);

    // Accesses outside the window leave the UART untouched
    bus.addr = 32'h0001_0000; #1;
    chk("hit_outside", 32'(bus.hit), 32'd0);
    f0 = frames;
    wr(32'h0001_0000, 32'hAB);
    wr(32'h0001_0008, 32'h0);
    repeat (60) tick();
    chk("frames_outside", 32'(frames), 32'(f0));
    rd(A_ST, rv); chk("status_outside", rv, status_word(0, 0, 1, 0, 0));
    rd(A_CT, rv); chk("ctrl_outside", rv, 32'h1);

    repeat (5) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor data port, downstream of the CPU's `address_to_mem`, `data_to_mem` and `WE` outputs. It decodes a 16-byte register window, queues written bytes in a small FIFO, and serialises them as 8N1 frames on `txd`. Its combinational read data and a hit flag let the top level choose between it and data memory for `data_from_mem`, and suppress data-memory writes on a hit.

## Interface
- `CLK_DIV`, 16: clk cycles per bit; ≥2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of 2, ≥2.
- `BASE_ADDR`, 32'h0000_FF00: window base; bits [3:0] ignored.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `we`  in  1  CPU write enable.
- `addr`  in  32  CPU byte address.
- `wdata`  in  32  CPU store data.
- `rdata`  out  32  register read data, combinational from `addr`.
- `hit`  out  1  combinational; high when addr[31:4] == BASE_ADDR[31:4].
- `txd`  out  1  serial output, registered; idle high.
- `irq`  out  1  registered; high when CTRL.IE=1, FIFO empty and FSM in IDLE.

## Operation
- Register offset is addr[3:2]. Writes commit on the clk edge where `we & hit`.
- 0x0 TXDATA:
  - Write pushes wdata[7:0].
  - Reads return 0.
- 0x4 STATUS (read):
  - bit0 busy (FSM not IDLE).
  - bit1 full.
  - bit2 empty.
  - bit3 overflow (sticky).
  - bits[11:8] FIFO count, saturating at 15.
  - Other bits 0.
  - Writing 1 to bit3 clears overflow; other bits ignored.
- 0x8 CTRL (R/W):
  - bit0 EN, reset 1.
  - bit1 IE, reset 0.
  - Other bits read 0.
- 0xC reserved: reads 0, writes ignored.
- Push while full with no pop in the same cycle: byte dropped, overflow set.
- Push while full with a pop in the same cycle: byte accepted, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when EN=1 and FIFO not empty. This transition pops the head byte into the shift register.
  - START: txd=0 for CLK_DIV cycles → DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each, 3-bit bit index → STOP.
  - STOP: txd=1 for CLK_DIV cycles. Then → START with an immediate pop if EN=1 and FIFO not empty; otherwise → IDLE.
- EN cleared mid-frame: current frame completes; no further pops.
- Bit-period counter width is clog2(CLK_DIV). It wraps to 0 at CLK_DIV-1.

## Timing
- Reset values:
  - txd=1, irq=0, FSM IDLE.
  - FIFO empty, overflow=0, EN=1, IE=0, counters 0.
  - rdata and hit follow addr combinationally; no reset.
- Reset mid-frame: at the next edge txd=1 and the FIFO is flushed; the partial frame is abandoned.
- Latency: a write committed at edge N to an idle, empty block gives IDLE→START at edge N+1; txd=0 from edge N+2.
- Frame length: exactly 10·CLK_DIV cycles. Back-to-back frames have no idle gap.
- Read-after-write: STATUS read in the cycle after a push reflects the new count.

## Structure
- Package `uart_pkg`:
  - register offset constants (`TXDATA_OFS`, `STATUS_OFS`, `CTRL_OFS`);
  - STATUS/CTRL bit positions;
  - FSM state enum `tx_state_t`.
- Sub-module `sync_fifo`: parameterised width and depth, push/pop/full/empty/count, synchronous reset, simultaneous push+pop legal when full.
- Top-level glue outside this block:
  - `data_from_mem = hit ? rdata : dmem_rdata`;
  - dmem write gated by `!hit`.

## Test plan
- Reset, then idle 50 cycles: txd=1, irq=0, STATUS=0x0000_0004, CTRL=0x1.
- CLK_DIV=4, write 0x5A to 0xFF00: txd goes 0 two edges later, then bits 0,1,0,1,1,0,1,0 over 4 cycles each, then 1. Busy clears after 40 cycles.
- Write 9 bytes back-to-back while idle, FIFO_DEPTH=8: first byte pops immediately, so all 9 are accepted and none overflow. A 10th write while full sets overflow; write 0x8 to STATUS clears it.
- 3 queued bytes: frames contiguous, no txd-high gap beyond the stop bits; total 30·CLK_DIV cycles.
- Assert reset during DATA bit 4: txd=1 next edge, STATUS empty, and no further start bit.
- Set IE and send 1 byte: irq=0 while busy, irq=1 after the stop bit, irq=0 on the next TXDATA write. A write to 0x1_0000 leaves hit=0 and the UART untouched.
